// File: rtl/viterbi_decoder_k3.sv
// Hard-decision Viterbi decoder for the rate-1/2 K=3 (7,5) code, register-exchange survivors.
// Define VITERBI_ERRCNT_EN to add the err_count channel-error estimate port.
module viterbi_decoder_k3 #(
   parameter int unsigned TB_DEPTH = 16,
   parameter int unsigned MW       = 6
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       in_valid,
   input  logic [1:0] parities,
   output logic       out,
   output logic       out_valid
`ifdef VITERBI_ERRCNT_EN
   ,
   output logic [15:0] err_count
`endif
);

   localparam int unsigned CntW = $clog2(TB_DEPTH + 1);
   localparam logic [CntW-1:0] CntMax  = CntW'(TB_DEPTH);
   localparam logic [CntW-1:0] CntFill = CntW'(TB_DEPTH - 1);
   localparam logic [MW-1:0] MetricInit = MW'(8);

   function automatic logic [1:0] hamming(input logic [1:0] diff);
      return {1'b0, diff[1]} + {1'b0, diff[0]};
   endfunction

   function automatic logic [MW-1:0] sat_add(input logic [MW-1:0] m, input logic [1:0] b);
      logic [MW:0] s;
      s = {1'b0, m} + {{(MW - 1){1'b0}}, b};
      return s[MW] ? '1 : s[MW-1:0];
   endfunction

   logic [MW-1:0]       metric_q [4];
   logic [TB_DEPTH-1:0] surv_q   [4];
   logic [CntW-1:0]     cnt_q;

   logic [MW-1:0]       raw_d  [4];
   logic [MW-1:0]       norm_d [4];
   logic [TB_DEPTH-1:0] surv_d [4];
   logic [MW-1:0]       min_val;
   logic [1:0]          min_idx;

   // Next state {n1,n0} has predecessors {0,n1} and {1,n1}; decided bit u is n0.
   for (genvar g = 0; g < 4; g++) begin : g_acs
      localparam logic [1:0] G = 2'(g);
      logic [1:0]    exp_a, exp_b;
      logic [MW-1:0] cand_a, cand_b;
      logic          sel_b;

      assign exp_a  = {G[0] ^ G[1], G[0]};
      assign exp_b  = {~(G[0] ^ G[1]), ~G[0]};
      assign cand_a = sat_add(metric_q[{1'b0, G[1]}], hamming(parities ^ exp_a));
      assign cand_b = sat_add(metric_q[{1'b1, G[1]}], hamming(parities ^ exp_b));
      assign sel_b  = cand_b < cand_a;
      assign raw_d[g]  = sel_b ? cand_b : cand_a;
      assign surv_d[g] = {sel_b ? surv_q[{1'b1, G[1]}][TB_DEPTH-2:0]
                                : surv_q[{1'b0, G[1]}][TB_DEPTH-2:0], G[0]};
   end

   // Strict compare keeps the lowest index on ties.
   always_comb begin
      min_val = raw_d[0];
      min_idx = 2'd0;
      for (int i = 1; i < 4; i++) begin
         if (raw_d[i] < min_val) begin
            min_val = raw_d[i];
            min_idx = 2'(i);
         end
      end
      for (int i = 0; i < 4; i++) begin
         norm_d[i] = raw_d[i] - min_val;
      end
   end

`ifdef VITERBI_ERRCNT_EN
   logic [16:0] err_sum;
   assign err_sum = {1'b0, err_count} + 17'(min_val);
`endif

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         for (int i = 0; i < 4; i++) begin
            metric_q[i] <= (i == 0) ? '0 : MetricInit;
            surv_q[i]   <= '0;
         end
         cnt_q     <= '0;
         out       <= 1'b0;
         out_valid <= 1'b0;
`ifdef VITERBI_ERRCNT_EN
         err_count <= '0;
`endif
      end else begin
         out_valid <= 1'b0;
         if (in_valid) begin
            metric_q <= norm_d;
            surv_q   <= surv_d;
            if (cnt_q != CntMax) begin
               cnt_q <= cnt_q + 1'b1;
            end
            if (cnt_q >= CntFill) begin
               out_valid <= 1'b1;
               out       <= surv_d[min_idx][TB_DEPTH-1];
            end
`ifdef VITERBI_ERRCNT_EN
            err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
`endif
         end
      end
   end

endmodule

// File: tb/tb_viterbi_decoder_k3.sv
// Randomised and directed bench for viterbi_decoder_k3 against a traceback-based reference decoder.
module tb_viterbi_decoder_k3;

   localparam int TB = 16;

   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   logic       in_valid = 1'b0;
   logic [1:0] parities = 2'b00;
   logic       out;
   logic       out_valid;
`ifdef VITERBI_ERRCNT_EN
   logic [15:0] err_count;
`endif

   viterbi_decoder_k3 #(.TB_DEPTH(TB), .MW(6)) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .in_valid  (in_valid),
      .parities  (parities),
      .out       (out),
      .out_valid (out_valid)
`ifdef VITERBI_ERRCNT_EN
      ,
      .err_count (err_count)
`endif
   );

   always #5 CLK = ~CLK;

   int n_vec = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input longint obs, input longint exp_v);
      n_vec++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
      end
   endtask

   // Reference: unnormalised path metrics, stored decisions, explicit traceback.
   int       m [4];
   bit [1:0] pred_hist [0:20099][4];
   int       nsym;
   bit       exp_out;
   bit       info_q [$];
   int       enc_st;

   function automatic int min_metric();
      int r = m[0];
      for (int i = 1; i < 4; i++) if (m[i] < r) r = m[i];
      return r;
   endfunction

   task automatic model_reset();
      m = '{0, 8, 8, 8};
      nsym = 0;
      exp_out = 1'b0;
   endtask

   task automatic model_step(input logic [1:0] p, output bit v, output bit b);
      int       nm [4];
      bit [1:0] pr [4];
      int       best, st;
      for (int n = 0; n < 4; n++) nm[n] = 32'h7fff_ffff;
      for (int s = 0; s < 4; s++) begin
         for (int u = 0; u < 2; u++) begin
            int n, e1, e0, d;
            n  = ((s & 1) << 1) | u;
            e1 = u ^ (s & 1) ^ (s >> 1);
            e0 = u ^ (s >> 1);
            d  = (int'(p[1]) != e1 ? 1 : 0) + (int'(p[0]) != e0 ? 1 : 0);
            if (m[s] + d < nm[n]) begin
               nm[n] = m[s] + d;
               pr[n] = 2'(s);
            end
         end
      end
      m = nm;
      pred_hist[nsym] = pr;
      nsym++;
      v = (nsym >= TB);
      b = 1'b0;
      if (v) begin
         best = 0;
         for (int i = 1; i < 4; i++) if (m[i] < m[best]) best = i;
         st = best;
         for (int j = nsym - 1; j > nsym - TB; j--) st = int'(pred_hist[j][st]);
         b = st[0];
      end
   endtask

   function automatic logic [1:0] encode(input bit u);
      logic [1:0] p;
      int s1, s0;
      s1 = enc_st >> 1;
      s0 = enc_st & 1;
      p = {1'(int'(u) ^ s0 ^ s1), 1'(int'(u) ^ s1)};
      enc_st = ((enc_st & 1) << 1) | int'(u);
      return p;
   endfunction

   task automatic step(input bit vld, input logic [1:0] p);
      bit ev, eb;
      int k;
      in_valid = vld;
      parities = p;
      @(posedge CLK);
      #1;
      ev = 1'b0;
      if (vld) begin
         model_step(p, ev, eb);
         if (ev) exp_out = eb;
      end
      check_eq("out_valid", out_valid, ev);
      check_eq("out", out, exp_out);
      if (ev) begin
         k = nsym - TB;
         if (k < info_q.size()) check_eq("info_bit", out, info_q[k]);
      end
`ifdef VITERBI_ERRCNT_EN
      check_eq("err_count", err_count, min_metric());
`endif
   endtask

   task automatic do_reset();
      RST_N = 1'b0;
      in_valid = 1'b1;
      parities = 2'b11;
      @(posedge CLK);
      #1;
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_out", out, 0);
`ifdef VITERBI_ERRCNT_EN
      check_eq("rst_err_count", err_count, 0);
`endif
      RST_N = 1'b1;
      in_valid = 1'b0;
      model_reset();
      enc_st = 0;
   endtask

   task automatic load_clean();
      bit base [6] = '{1, 0, 1, 1, 0, 0};
      info_q.delete();
      foreach (base[i]) info_q.push_back(base[i]);
      for (int i = 0; i < TB; i++) info_q.push_back(1'b0);
   endtask

   // gaps: idle cycles after each symbol; bad_idx: symbol forced to 00 (-1 for none).
   task automatic send_info(input int gaps, input int bad_idx, input int limit);
      logic [1:0] p;
      for (int i = 0; i < info_q.size() && i < limit; i++) begin
         p = encode(info_q[i]);
         if (i == bad_idx) p = 2'b00;
         step(1'b1, p);
         for (int g = 0; g < gaps; g++) step(1'b0, 2'($urandom_range(0, 3)));
      end
   endtask

   initial begin
      int next_err;
      logic [1:0] p;
      model_reset();
      enc_st = 0;

      do_reset();
      step(1'b0, 2'b00);

      // Directed: the six-bit example must encode to its published parities.
      load_clean();
      begin
         logic [1:0] ref_p [6] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
         for (int i = 0; i < 6; i++) check_eq("encoder", encode(info_q[i]), ref_p[i]);
      end

      do_reset();
      send_info(0, -1, 1 << 30);

      do_reset();
      send_info(0, 1, 1 << 30);

      do_reset();
      send_info(3, -1, 1 << 30);

      do_reset();
      send_info(0, -1, 10);
      do_reset();
      send_info(0, -1, 1 << 30);

      do_reset();
      info_q.delete();
      for (int i = 0; i < 1000; i++) info_q.push_back(1'b0);
      send_info(0, -1, 1 << 30);

      do_reset();
      info_q.delete();
      for (int i = 0; i < 10000; i++) info_q.push_back(1'($urandom_range(0, 1)));
      for (int i = 0; i < TB + 1; i++) info_q.push_back(1'b0);
      next_err = 10 + $urandom_range(0, 20);
      for (int i = 0; i < info_q.size(); i++) begin
         p = encode(info_q[i]);
         if (i == next_err) begin
            p ^= ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
            next_err = i + 10 + $urandom_range(0, 20);
         end
         step(1'b1, p);
         if ($urandom_range(0, 15) == 0) step(1'b0, 2'($urandom_range(0, 3)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
